addsub_arbiter: RTL and testbench
=================================

Name: addsub_arbiter

Overview:
Shares one combinational 4-bit add/subtract datapath between two independent requesters. Each requester uses a valid/ready handshake. A round-robin arbiter grants one operation at a time. The block sequences each granted operation through capture, execute and respond phases, and holds the 5-bit result plus overflow flag until the owner accepts it. It sits between the ALU front-end ports and the shared arithmetic core.

Parameters:
WIDTH, 4, operand width; result width is WIDTH+1
OPW, 2, opcode width

Ports:
clk  input  1  single system clock, rising edge
rst  input  1  synchronous, active-high reset
req0_valid  input  1  requester 0 has an operation
req0_ready  output  1  requester 0 operation accepted this cycle
req0_op  input  OPW  opcode: 2'b01 add, 2'b10 sub, 2'b00/2'b11 reserved
req0_a  input  WIDTH  operand A
req0_b  input  WIDTH  operand B
rsp0_valid  output  1  result for requester 0 available
rsp0_ready  input  1  requester 0 accepts result
rsp0_y  output  WIDTH+1  result
rsp0_ovf  output  1  signed two's-complement overflow
rsp0_err  output  1  reserved opcode was issued
req1_*/rsp1_*  same set for requester 1
busy  output  1  operation in flight (state != IDLE)

Behaviour:
- Reset (sync, rst=1 at clk edge):
  - state=IDLE, rr pointer=0 (requester 0 preferred).
  - All outputs 0: rsp*_y, rsp*_ovf, rsp*_err, rsp*_valid, req*_ready, busy.
  - Reset mid-operation discards the captured op; no response is produced.
- FSM states are IDLE, EXEC and RESP.
- IDLE:
  - If any reqN_valid is asserted, grant one requester: if both are valid, grant the rr pointer's requester, otherwise the sole valid one.
  - reqN_ready=1 for the granted requester only, same cycle (combinational from state, valid and pointer).
  - On that edge: capture op, a, b and owner; toggle the pointer to the non-granted index; go to EXEC.
  - The ungranted requester must hold its inputs stable.
- EXEC (1 cycle):
  - Drive the captured operands and opcode into the core.
  - Register y, ovf and err into the owner's response registers; go to RESP.
- RESP:
  - rspN_valid=1 for the owner only; rsp y/ovf/err are stable while valid.
  - When rspN_ready=1: clear valid and go to IDLE.
  - No new grant is made in the RESP->IDLE cycle.
- Latency and throughput:
  - req handshake to rsp_valid: 2 cycles.
  - Minimum 3 cycles per operation if rsp_ready is held high.
- Fairness: with both requesters continuously valid, grants strictly alternate. Max wait is one foreign operation.
- Arithmetic (WIDTH=4):
  - add: y = {carry, A+B}, unsigned 5-bit sum.
  - sub: y[3:0] = (A-B) mod 16; y[4] = borrow (1 iff A<B unsigned).
  - ovf:
    - add: 1 iff A,B same sign and sum[3] differs.
    - sub: 1 iff A,B differ in sign and y[3] != A[3].
  - Reserved opcode: y=0, ovf=0, err=1; still a normal handshake and response.
- Output hold: rspN_y, rspN_ovf and rspN_err retain their last value after valid drops; they are only updated at EXEC for the owner.
- busy: 1 in EXEC and RESP.

Decomposition:
- Shared package: opcode constants OP_ADD=2'b01, OP_SUB=2'b10; state encoding IDLE/EXEC/RESP; WIDTH default.
- Sub-module addsub_core: purely combinational, inputs op, a, b; outputs y, ovf, err. The arbiter instantiates exactly one.

Test Plan:
- Reset: rst high 2 cycles with req0_valid=1 -> all outputs 0, req0_ready stays 0 during reset; after release, req0_ready=1 on the first cycle.
- req0 sub A=4'd5, B=4'd3 -> rsp0_valid 2 cycles after handshake, y=5'b00010, ovf=0, err=0. Then A=3, B=5 -> y=5'b11110 (borrow 1), ovf=0.
- req1 sub A=4'b0111, B=4'b1111 -> y=5'b11000, ovf=1. Then add A=4'd9, B=4'd8 -> y=5'b10001, ovf=1.
- Both valid from reset, rsp_ready tied 1, 6 operations -> grant order 0,1,0,1,0,1. Each owner's rsp values are correct; the other rsp_valid is never asserted.
- Backpressure: rsp0_ready=0 for 5 cycles while req1_valid=1 -> rsp0_valid/y held stable, req1_ready=0 throughout. req1 is granted in the IDLE cycle after the rsp0 handshake.
- Reserved op 2'b11 on req0 -> err=1, y=0, ovf=0. Assert rst during EXEC -> no rsp0_valid, state IDLE, pointer back to 0.

Source files
------------

// File: rtl/addsub_arbiter_pkg.sv
// Shared definitions for the two-requester add/subtract arbiter.
// Holds the opcode encodings, the FSM state type and the default widths
// used by addsub_core and addsub_arbiter.
package addsub_arbiter_pkg;

   localparam int WIDTH_DEF = 4;
   localparam int OPW_DEF   = 2;

   localparam logic [1:0] OP_ADD = 2'b01;
   localparam logic [1:0] OP_SUB = 2'b10;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

endpackage

// File: rtl/addsub_core.sv
// Combinational add/subtract datapath shared by both requesters.
// Ports:
//   op  - opcode (OP_ADD / OP_SUB, anything else is reserved)
//   a,b - unsigned operands, also interpreted as two's complement for ovf
//   y   - WIDTH+1 result: carry-out on add, borrow on sub
//   ovf - signed two's-complement overflow
//   err - reserved opcode seen (y and ovf forced to 0)
module addsub_core
   import addsub_arbiter_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int OPW   = OPW_DEF
) (
   input  logic [OPW-1:0]   op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH:0]   y,
   output logic             ovf,
   output logic             err
);

   logic [WIDTH:0] sum;
   logic [WIDTH:0] diff;

   // Zero-extended arithmetic: the top bit of diff is the borrow (a < b).
   assign sum  = {1'b0, a} + {1'b0, b};
   assign diff = {1'b0, a} - {1'b0, b};

   always_comb begin
      y   = '0;
      ovf = 1'b0;
      err = 1'b0;
      if (op == OPW'(OP_ADD)) begin
         y   = sum;
         ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end else if (op == OPW'(OP_SUB)) begin
         y   = diff;
         ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end else begin
         err = 1'b1;
      end
   end

endmodule

// File: rtl/addsub_arbiter.sv
// Round-robin arbiter sharing one addsub_core between two requesters.
// Each operation runs IDLE (grant/capture) -> EXEC (compute/register)
// -> RESP (hold result until the owner accepts it).
// Ports:
//   clk, rst          - clock and synchronous active-high reset
//   reqN_valid/ready  - operation handshake (ready is combinational in IDLE)
//   reqN_op/a/b       - opcode and operands
//   rspN_valid/ready  - result handshake
//   rspN_y/ovf/err    - result registers, held after valid drops
//   busy              - an operation is in flight
module addsub_arbiter
   import addsub_arbiter_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int OPW   = OPW_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [OPW-1:0]   req0_op,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   output logic             rsp0_valid,
   input  logic             rsp0_ready,
   output logic [WIDTH:0]   rsp0_y,
   output logic             rsp0_ovf,
   output logic             rsp0_err,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [OPW-1:0]   req1_op,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   output logic             rsp1_valid,
   input  logic             rsp1_ready,
   output logic [WIDTH:0]   rsp1_y,
   output logic             rsp1_ovf,
   output logic             rsp1_err,
   output logic             busy
);

   state_t           state;
   logic             rr;       // preferred requester when both are valid
   logic             owner;    // requester whose op is in flight
   logic [OPW-1:0]   cap_op;
   logic [WIDTH-1:0] cap_a;
   logic [WIDTH-1:0] cap_b;

   logic             any_valid;
   logic             grant;
   logic             owner_rsp_ready;
   logic [WIDTH:0]   core_y;
   logic             core_ovf;
   logic             core_err;

   assign any_valid = req0_valid | req1_valid;
   // Pointer only matters on contention; otherwise the sole valid side wins.
   assign grant     = (req0_valid && req1_valid) ? rr : req1_valid;

   // Gated by rst so nothing is accepted while reset is held.
   assign req0_ready = !rst && (state == IDLE) && any_valid && !grant;
   assign req1_ready = !rst && (state == IDLE) && any_valid &&  grant;

   assign owner_rsp_ready = owner ? rsp1_ready : rsp0_ready;
   assign busy            = (state != IDLE);

   addsub_core #(.WIDTH(WIDTH), .OPW(OPW)) u_core (
      .op  (cap_op),
      .a   (cap_a),
      .b   (cap_b),
      .y   (core_y),
      .ovf (core_ovf),
      .err (core_err)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         rr         <= 1'b0;
         owner      <= 1'b0;
         cap_op     <= '0;
         cap_a      <= '0;
         cap_b      <= '0;
         rsp0_valid <= 1'b0;
         rsp0_y     <= '0;
         rsp0_ovf   <= 1'b0;
         rsp0_err   <= 1'b0;
         rsp1_valid <= 1'b0;
         rsp1_y     <= '0;
         rsp1_ovf   <= 1'b0;
         rsp1_err   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (any_valid) begin
                  owner  <= grant;
                  cap_op <= grant ? req1_op : req0_op;
                  cap_a  <= grant ? req1_a  : req0_a;
                  cap_b  <= grant ? req1_b  : req0_b;
                  rr     <= ~grant;
                  state  <= EXEC;
               end
            end
            EXEC: begin
               // Only the owner's result registers change; the other side holds.
               if (owner) begin
                  rsp1_y     <= core_y;
                  rsp1_ovf   <= core_ovf;
                  rsp1_err   <= core_err;
                  rsp1_valid <= 1'b1;
               end else begin
                  rsp0_y     <= core_y;
                  rsp0_ovf   <= core_ovf;
                  rsp0_err   <= core_err;
                  rsp0_valid <= 1'b1;
               end
               state <= RESP;
            end
            RESP: begin
               if (owner_rsp_ready) begin
                  rsp0_valid <= 1'b0;
                  rsp1_valid <= 1'b0;
                  state      <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_addsub_arbiter.sv
// Self-checking bench for addsub_arbiter: directed scenarios plus random
// operations compared against a signed/unsigned arithmetic reference model.
module tb_addsub_arbiter;

   logic       clk = 1'b0;
   logic       rst;
   logic       req0_valid, req0_ready, req1_valid, req1_ready;
   logic [1:0] req0_op, req1_op;
   logic [3:0] req0_a, req0_b, req1_a, req1_b;
   logic       rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
   logic [4:0] rsp0_y, rsp1_y;
   logic       rsp0_ovf, rsp0_err, rsp1_ovf, rsp1_err;
   logic       busy;

   int passed = 0;
   int total  = 0;

   always #5 clk = ~clk;

   addsub_arbiter dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
      .req0_a(req0_a), .req0_b(req0_b),
      .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_y(rsp0_y),
      .rsp0_ovf(rsp0_ovf), .rsp0_err(rsp0_err),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
      .req1_a(req1_a), .req1_b(req1_b),
      .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_y(rsp1_y),
      .rsp1_ovf(rsp1_ovf), .rsp1_err(rsp1_err),
      .busy(busy)
   );

   // Reference: returns {err, ovf, y[4:0]} from plain integer arithmetic.
   function automatic logic [6:0] model(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
      int ua, ub, sa, sb, r, s;
      logic [4:0] y;
      ua = int'(a); ub = int'(b);
      sa = (ua > 7) ? ua - 16 : ua;
      sb = (ub > 7) ? ub - 16 : ub;
      if (op == 2'b01) begin
         r = ua + ub; s = sa + sb;
      end else if (op == 2'b10) begin
         r = ua - ub; s = sa - sb;
      end else begin
         return {1'b1, 1'b0, 5'd0};
      end
      y = 5'((r + 32) % 32);
      return {1'b0, (s > 7 || s < -8), y};
   endfunction

   task automatic do_reset();
      rst = 1'b1;
      req0_valid = 0; req1_valid = 0; rsp0_ready = 0; rsp1_ready = 0;
      req0_op = 0; req0_a = 0; req0_b = 0;
      req1_op = 0; req1_a = 0; req1_b = 0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   // Drives one operation end-to-end with rsp_ready held high; reports observations.
   task automatic run_op(input int idx, input logic [1:0] op, input logic [3:0] a, input logic [3:0] b,
                         output bit hs, output int lat, output logic [6:0] res, output bit other);
      int n;
      hs = 0; lat = 0; res = '0; other = 0;
      if (idx == 0) begin
         req0_op = op; req0_a = a; req0_b = b; req0_valid = 1; rsp0_ready = 1;
      end else begin
         req1_op = op; req1_a = a; req1_b = b; req1_valid = 1; rsp1_ready = 1;
      end
      #1;
      n = 0;
      while (((idx == 0) ? req0_ready : req1_ready) !== 1'b1 && n < 20) begin
         @(posedge clk); #1; n++;
      end
      if (((idx == 0) ? req0_ready : req1_ready) === 1'b1) begin
         hs = 1;
         @(posedge clk); #1;
         req0_valid = 0; req1_valid = 0;
         lat = 1;
         while (((idx == 0) ? rsp0_valid : rsp1_valid) !== 1'b1 && lat < 10) begin
            if (((idx == 0) ? rsp1_valid : rsp0_valid) !== 1'b0) other = 1;
            @(posedge clk); #1; lat++;
         end
         if (((idx == 0) ? rsp1_valid : rsp0_valid) !== 1'b0) other = 1;
         res = (idx == 0) ? {rsp0_err, rsp0_ovf, rsp0_y} : {rsp1_err, rsp1_ovf, rsp1_y};
         @(posedge clk); #1;
      end
      req0_valid = 0; req1_valid = 0; rsp0_ready = 0; rsp1_ready = 0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      req0_valid = 1; req0_op = 2'b01; req0_a = 4'd1; req0_b = 4'd2;
      req1_valid = 0; req1_op = 0; req1_a = 0; req1_b = 0;
      rsp0_ready = 0; rsp1_ready = 0;
      for (int c = 0; c < 2; c++) begin
         @(posedge clk); #1;
         total++;
         if (req0_ready !== 1'b0) $display("FAIL reset_req0_ready cyc%0d got %b exp 0", c, req0_ready); else passed++;
         total++;
         if ({req1_ready, rsp0_valid, rsp1_valid, busy} !== 4'b0)
            $display("FAIL reset_ctrl cyc%0d got %b exp 0000", c, {req1_ready, rsp0_valid, rsp1_valid, busy}); else passed++;
         total++;
         if ({rsp0_y, rsp0_ovf, rsp0_err, rsp1_y, rsp1_ovf, rsp1_err} !== 14'd0)
            $display("FAIL reset_data cyc%0d got %h exp 0", c, {rsp0_y, rsp0_ovf, rsp0_err, rsp1_y, rsp1_ovf, rsp1_err}); else passed++;
      end
      rst = 1'b0; #1;
      total++;
      if (req0_ready !== 1'b1) $display("FAIL reset_release_ready got %b exp 1", req0_ready); else passed++;
      req0_valid = 0;
   endtask

   task automatic test_sub_req0();
      bit hs, oth; int lat; logic [6:0] r;
      do_reset();
      run_op(0, 2'b10, 4'd5, 4'd3, hs, lat, r, oth);
      total++;
      if (!hs || lat != 2) $display("FAIL sub0_latency hs=%0d got %0d exp 2", hs, lat); else passed++;
      total++;
      if (r !== {1'b0, 1'b0, 5'b00010}) $display("FAIL sub0_5m3 got %b exp 0000010", r); else passed++;
      total++;
      if (rsp0_y !== 5'b00010 || rsp0_valid !== 1'b0)
         $display("FAIL sub0_hold got y=%b v=%b exp y=00010 v=0", rsp0_y, rsp0_valid); else passed++;
      run_op(0, 2'b10, 4'd3, 4'd5, hs, lat, r, oth);
      total++;
      if (r !== {1'b0, 1'b0, 5'b11110}) $display("FAIL sub0_3m5 got %b exp 0011110", r); else passed++;
      total++;
      if (oth) $display("FAIL sub0_other_valid got 1 exp 0"); else passed++;
   endtask

   task automatic test_req1();
      bit hs, oth; int lat; logic [6:0] r;
      do_reset();
      run_op(1, 2'b10, 4'b0111, 4'b1111, hs, lat, r, oth);
      total++;
      if (!hs || lat != 2) $display("FAIL req1_latency hs=%0d got %0d exp 2", hs, lat); else passed++;
      total++;
      if (r !== {1'b0, 1'b1, 5'b11000}) $display("FAIL req1_sub got %b exp 0111000", r); else passed++;
      run_op(1, 2'b01, 4'd9, 4'd8, hs, lat, r, oth);
      total++;
      if (r !== {1'b0, 1'b1, 5'b10001}) $display("FAIL req1_add got %b exp 0110001", r); else passed++;
      total++;
      if (oth || rsp0_y !== 5'd0) $display("FAIL req1_rsp0_untouched got oth=%0d y=%b exp 0", oth, rsp0_y); else passed++;
   endtask

   task automatic test_fairness();
      int gq[$];
      logic [6:0] e0[$], e1[$];
      int nrsp, cyc;
      bit both_rdy, both_rsp, g0, g1;
      nrsp = 0; cyc = 0; both_rdy = 0; both_rsp = 0;
      do_reset();
      rsp0_ready = 1; rsp1_ready = 1;
      req0_op = 2'($urandom_range(1, 2)); req0_a = 4'($urandom); req0_b = 4'($urandom);
      req1_op = 2'($urandom_range(1, 2)); req1_a = 4'($urandom); req1_b = 4'($urandom);
      req0_valid = 1; req1_valid = 1;
      #1;
      while (nrsp < 6 && cyc < 60) begin
         if (req0_ready === 1'b1 && req1_ready === 1'b1) both_rdy = 1;
         g0 = (req0_ready === 1'b1); g1 = (req1_ready === 1'b1);
         if (g0) begin gq.push_back(0); e0.push_back(model(req0_op, req0_a, req0_b)); end
         if (g1) begin gq.push_back(1); e1.push_back(model(req1_op, req1_a, req1_b)); end
         if (rsp0_valid === 1'b1 && rsp1_valid === 1'b1) both_rsp = 1;
         if (rsp0_valid === 1'b1) begin
            nrsp++; total++;
            if (e0.size() == 0 || {rsp0_err, rsp0_ovf, rsp0_y} !== e0[0])
               $display("FAIL fair_rsp0 got %b exp %b", {rsp0_err, rsp0_ovf, rsp0_y}, (e0.size() != 0) ? e0[0] : 7'bx);
            else passed++;
            if (e0.size() != 0) void'(e0.pop_front());
         end
         if (rsp1_valid === 1'b1) begin
            nrsp++; total++;
            if (e1.size() == 0 || {rsp1_err, rsp1_ovf, rsp1_y} !== e1[0])
               $display("FAIL fair_rsp1 got %b exp %b", {rsp1_err, rsp1_ovf, rsp1_y}, (e1.size() != 0) ? e1[0] : 7'bx);
            else passed++;
            if (e1.size() != 0) void'(e1.pop_front());
         end
         if (nrsp >= 6) break;
         @(posedge clk); #1; cyc++;
         if (g0) begin req0_op = 2'($urandom_range(1, 2)); req0_a = 4'($urandom); req0_b = 4'($urandom); end
         if (g1) begin req1_op = 2'($urandom_range(1, 2)); req1_a = 4'($urandom); req1_b = 4'($urandom); end
         #1;
      end
      req0_valid = 0; req1_valid = 0;
      total++;
      if (nrsp != 6) $display("FAIL fair_count got %0d exp 6 responses", nrsp); else passed++;
      total++;
      if (both_rdy || both_rsp) $display("FAIL fair_exclusive got rdy=%0d rsp=%0d exp 0 0", both_rdy, both_rsp); else passed++;
      for (int i = 0; i < 6; i++) begin
         total++;
         if (i >= gq.size() || gq[i] != i % 2)
            $display("FAIL fair_order idx%0d got %0d exp %0d", i, (i < gq.size()) ? gq[i] : -1, i % 2);
         else passed++;
      end
      @(posedge clk); #1;
   endtask

   task automatic test_backpressure();
      logic [6:0] ex0, ex1, snap;
      do_reset();
      req0_op = 2'b10; req0_a = 4'($urandom); req0_b = 4'($urandom);
      req1_op = 2'b01; req1_a = 4'($urandom); req1_b = 4'($urandom);
      ex0 = model(req0_op, req0_a, req0_b);
      ex1 = model(req1_op, req1_a, req1_b);
      req0_valid = 1; req1_valid = 1; #1;
      total++;
      if ({req0_ready, req1_ready} !== 2'b10) $display("FAIL bp_first_grant got %b exp 10", {req0_ready, req1_ready}); else passed++;
      @(posedge clk); #1;
      req0_valid = 0;
      @(posedge clk); #1;
      snap = {rsp0_err, rsp0_ovf, rsp0_y};
      total++;
      if (rsp0_valid !== 1'b1 || snap !== ex0) $display("FAIL bp_rsp0 got v=%b %b exp v=1 %b", rsp0_valid, snap, ex0); else passed++;
      for (int c = 0; c < 5; c++) begin
         @(posedge clk); #1;
         total++;
         if (rsp0_valid !== 1'b1 || {rsp0_err, rsp0_ovf, rsp0_y} !== ex0 || req1_ready !== 1'b0)
            $display("FAIL bp_hold cyc%0d got v=%b %b r1=%b exp v=1 %b r1=0", c, rsp0_valid,
                     {rsp0_err, rsp0_ovf, rsp0_y}, req1_ready, ex0);
         else passed++;
      end
      rsp0_ready = 1; #1;
      total++;
      if (req1_ready !== 1'b0) $display("FAIL bp_no_grant_in_resp got %b exp 0", req1_ready); else passed++;
      @(posedge clk); #1;
      rsp0_ready = 0; #1;
      total++;
      if (rsp0_valid !== 1'b0 || req1_ready !== 1'b1 || {rsp0_err, rsp0_ovf, rsp0_y} !== ex0)
         $display("FAIL bp_idle got v0=%b r1=%b %b exp v0=0 r1=1 %b", rsp0_valid, req1_ready, {rsp0_err, rsp0_ovf, rsp0_y}, ex0);
      else passed++;
      @(posedge clk); #1;
      req1_valid = 0;
      @(posedge clk); #1;
      total++;
      if (rsp1_valid !== 1'b1 || {rsp1_err, rsp1_ovf, rsp1_y} !== ex1)
         $display("FAIL bp_rsp1 got v=%b %b exp v=1 %b", rsp1_valid, {rsp1_err, rsp1_ovf, rsp1_y}, ex1);
      else passed++;
      rsp1_ready = 1;
      @(posedge clk); #1;
      rsp1_ready = 0;
      total++;
      if (rsp1_valid !== 1'b0 || busy !== 1'b0) $display("FAIL bp_done got v=%b busy=%b exp 0 0", rsp1_valid, busy); else passed++;
   endtask

   task automatic test_reserved_and_reset();
      bit hs, oth; int lat; logic [6:0] r;
      do_reset();
      run_op(0, 2'b11, 4'($urandom), 4'($urandom), hs, lat, r, oth);
      total++;
      if (!hs || lat != 2 || r !== 7'b1000000) $display("FAIL reserved_11 hs=%0d lat=%0d got %b exp 1000000", hs, lat, r); else passed++;
      run_op(1, 2'b00, 4'($urandom), 4'($urandom), hs, lat, r, oth);
      total++;
      if (r !== 7'b1000000) $display("FAIL reserved_00 got %b exp 1000000", r); else passed++;
      // Grant req0 (pointer moves to 1), then reset while in EXEC.
      req0_op = 2'b01; req0_a = 4'd3; req0_b = 4'd4; req0_valid = 1; rsp0_ready = 1; #1;
      @(posedge clk); #1;
      req0_valid = 0;
      total++;
      if (busy !== 1'b1) $display("FAIL rst_exec_busy got %b exp 1", busy); else passed++;
      rst = 1;
      @(posedge clk); #1;
      rst = 0;
      for (int c = 0; c < 2; c++) begin
         total++;
         if (rsp0_valid !== 1'b0 || busy !== 1'b0) $display("FAIL rst_exec_discard cyc%0d got v=%b busy=%b exp 0 0", c, rsp0_valid, busy); else passed++;
         @(posedge clk); #1;
      end
      req0_valid = 1; req1_valid = 1; #1;
      total++;
      if ({req0_ready, req1_ready} !== 2'b10) $display("FAIL rst_exec_pointer got %b exp 10", {req0_ready, req1_ready}); else passed++;
      req0_valid = 0; req1_valid = 0; rsp0_ready = 0;
   endtask

   task automatic test_random();
      bit hs, oth; int lat, idx; logic [1:0] op; logic [3:0] a, b; logic [6:0] r, e;
      do_reset();
      for (int i = 0; i < 20; i++) begin
         idx = int'($urandom_range(0, 1));
         op = (i % 5 == 4) ? 2'($urandom) : 2'($urandom_range(1, 2));
         a = 4'($urandom); b = 4'($urandom);
         e = model(op, a, b);
         run_op(idx, op, a, b, hs, lat, r, oth);
         total++;
         if (!hs || lat != 2 || oth || r !== e)
            $display("FAIL random%0d req%0d op=%b a=%h b=%h got %b hs=%0d lat=%0d oth=%0d exp %b", i, idx, op, a, b, r, hs, lat, oth, e);
         else passed++;
      end
   endtask

   initial begin
      test_reset();
      test_sub_req0();
      test_req1();
      test_fairness();
      test_backpressure();
      test_reserved_and_reset();
      test_random();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
